// File: rtl/aes_decrypt_pipelined.sv
// AES-128 inverse cipher that takes one ciphertext block per clock and returns it
// Nr+1 register stages later. Each block carries a valid bit and a user tag.
module aes_decrypt_pipelined #(
   parameter int Nr    = 10,
   parameter int TAG_W = 8,
   parameter int CNT_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [127:0]          in_data,
   input  logic                  in_valid,
   input  logic [TAG_W-1:0]      in_tag,
   input  logic [(Nr+1)*128-1:0] allKeys,
   input  logic                  key_valid,
   output logic [127:0]          out_data,
   output logic                  out_valid,
   output logic [TAG_W-1:0]      out_tag,
   output logic [CNT_W-1:0]      in_flight,
   output logic                  busy,
   output logic                  drop
);

   // Row-major inverse S-box, byte 0x00 in the top bits.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] x2, x4, x8;
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [127:0] add_round_key(input logic [127:0] state, input logic [127:0] key);
      return state ^ key;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] state);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++)
         o[8*i +: 8] = INV_SBOX[(255 - int'(state[8*i +: 8])) * 8 +: 8];
      return o;
   endfunction

   // Row r rotates right by r columns; byte index is row + 4*column.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] state);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] state);
      logic [127:0] o;
      logic [7:0]   a [4];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++)
            a[r] = state[127 - 8*(4*c + r) -: 8];
         for (int r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = gmul(a[r], 4'he) ^ gmul(a[(r + 1) % 4], 4'hb) ^
                                        gmul(a[(r + 2) % 4], 4'hd) ^ gmul(a[(r + 3) % 4], 4'h9);
      end
      return o;
   endfunction

   logic [127:0]     rk       [Nr+1];
   logic [127:0]     st_data  [Nr];
   logic [TAG_W-1:0] st_tag   [Nr];
   logic [Nr-1:0]    st_valid;
   logic [127:0]     final_state;

   for (genvar k = 0; k <= Nr; k++) begin : g_rk
      assign rk[k] = allKeys[(Nr - k)*128 +: 128];
   end

   assign final_state = add_round_key(inv_sub_bytes(inv_shift_rows(st_data[Nr-1])), rk[0]);

   // Invalid slots still load their data registers; only the output register is gated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < Nr; i++) begin
            st_data[i] <= '0;
            st_tag[i]  <= '0;
         end
         st_valid  <= '0;
         out_data  <= '0;
         out_tag   <= '0;
         out_valid <= 1'b0;
         drop      <= 1'b0;
      end else begin
         st_data[0] <= add_round_key(in_data, rk[Nr]);
         st_tag[0]  <= in_tag;
         for (int i = 1; i < Nr; i++) begin
            st_data[i] <= inv_mix_columns(add_round_key(inv_sub_bytes(inv_shift_rows(st_data[i-1])),
                                                        rk[Nr-i]));
            st_tag[i]  <= st_tag[i-1];
         end
         st_valid  <= {st_valid[Nr-2:0], in_valid & key_valid};
         out_valid <= st_valid[Nr-1];
         if (st_valid[Nr-1]) begin
            out_data <= final_state;
            out_tag  <= st_tag[Nr-1];
         end
         drop <= in_valid & ~key_valid;
      end
   end

   assign in_flight = CNT_W'($countones(st_valid));
   assign busy      = (in_flight != '0) | out_valid;

endmodule

// File: tb/tb_aes_decrypt_pipelined.sv
// Bench for aes_decrypt_pipelined: a forward AES-128 model generates ciphertexts and
// a timeline of accepted blocks predicts every output cycle by cycle.
module tb_aes_decrypt_pipelined;
   localparam int TAG_W = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [127:0]     in_data;
   logic             in_valid;
   logic [TAG_W-1:0] in_tag;
   logic [1407:0]    allKeys;
   logic             key_valid;
   logic [127:0]     out_data;
   logic             out_valid;
   logic [TAG_W-1:0] out_tag;
   logic [CNT_W-1:0] in_flight;
   logic             busy;
   logic             drop;

   always #5 clk = ~clk;

   aes_decrypt_pipelined #(.Nr(10), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_tag(in_tag),
      .allKeys(allKeys), .key_valid(key_valid), .out_data(out_data), .out_valid(out_valid),
      .out_tag(out_tag), .in_flight(in_flight), .busy(busy), .drop(drop)
   );

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      logic [7:0]   tag;
   } vec_t;

   typedef struct {
      logic [127:0] pt;
      logic [7:0]   tag;
   } exp_t;

   int           errors = 0;
   int           checks = 0;
   logic [7:0]   sbox_t [256];
   exp_t         exp_q [$];
   bit           hist [11];
   bit           exp_drop = 1'b0;
   logic [127:0] last_out = '0;
   logic [7:0]   last_tag = '0;
   int           accepts = 0;
   int           dut_outs = 0;
   int           dut_drops = 0;
   int           max_flight = 0;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] b;
      b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul8(b, x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [1407:0] expand_key(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] ak;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++)
         ak[(10 - r)*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return ak;
   endfunction

   function automatic logic [127:0] encrypt(input logic [1407:0] ak, input logic [127:0] pt);
      logic [7:0]   st [16];
      logic [7:0]   ns [16];
      logic [127:0] s;
      s = pt ^ ak[1407 -: 128];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) st[i] = sbox_t[s[127 - 8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) ns[4*c + r] = st[4*((c + r) % 4) + r];
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  st[4*c + r] = gmul8(ns[4*c + r], 8'd2) ^ gmul8(ns[4*c + (r + 1) % 4], 8'd3) ^
                                ns[4*c + (r + 2) % 4] ^ ns[4*c + (r + 3) % 4];
         end else begin
            st = ns;
         end
         for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = st[i];
         s = s ^ ak[(10 - rnd)*128 +: 128];
      end
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int   fl;
      exp_t e;
      fl = 0;
      for (int i = 0; i < 10; i++) fl += int'(hist[i]);
      chk("out_valid", 128'(out_valid), 128'(hist[10]));
      chk("in_flight", 128'(in_flight), 128'(fl));
      chk("busy", 128'(busy), 128'((fl != 0) || hist[10]));
      chk("drop", 128'(drop), 128'(exp_drop));
      if (hist[10]) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: output expected but no block pending at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            last_out = e.pt;
            last_tag = e.tag;
         end
      end
      chk("out_data", out_data, last_out);
      chk("out_tag", 128'(out_tag), 128'(last_tag));
      if (out_valid) dut_outs++;
      if (drop) dut_drops++;
      if (int'(in_flight) > max_flight) max_flight = int'(in_flight);
   endtask

   task automatic cycle(input bit iv, input bit kv, input logic [127:0] d, input logic [7:0] tg,
                        input logic [127:0] pt);
      exp_t e;
      in_valid  = iv;
      key_valid = kv;
      in_data   = d;
      in_tag    = tg;
      @(posedge clk);
      for (int i = 10; i > 0; i--) hist[i] = hist[i-1];
      hist[0]  = iv && kv;
      exp_drop = iv && !kv;
      if (iv && kv) begin
         e.pt  = pt;
         e.tag = tg;
         exp_q.push_back(e);
         accepts++;
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, rand128(), 8'(i), '0);
   endtask

   task automatic clear_model();
      for (int i = 0; i <= 10; i++) hist[i] = 1'b0;
      accepts -= exp_q.size();
      exp_q.delete();
      exp_drop = 1'b0;
      last_out = '0;
      last_tag = '0;
   endtask

   vec_t         vt [6];
   logic [127:0] pt, ct, key;
   logic [1407:0] ak;

   initial begin
      for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

      vt[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt: 128'h00112233445566778899aabbccddeeff, tag: 8'h5a};
      vt[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                pt: 128'h3243f6a8885a308d313198a2e0370734, tag: 8'hc3};
      for (int i = 2; i < 6; i++) begin
         vt[i].key = rand128();
         vt[i].pt  = (i == 2) ? '0 : rand128();
         vt[i].ct  = encrypt(expand_key(vt[i].key), vt[i].pt);
         vt[i].tag = 8'(i * 37);
      end

      reset = 1'b1;
      in_valid = 1'b0;
      key_valid = 1'b0;
      in_data = '0;
      in_tag = '0;
      allKeys = '0;
      @(posedge clk);
      #1;
      check_outputs();
      reset = 1'b0;

      // Single blocks, each fully drained before the key changes.
      for (int i = 0; i < 6; i++) begin
         allKeys = expand_key(vt[i].key);
         cycle(1'b1, 1'b1, vt[i].ct, vt[i].tag, vt[i].pt);
         idle(11);
      end

      // Sixteen back-to-back blocks.
      ak = expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
      allKeys = ak;
      max_flight = 0;
      for (int i = 0; i < 16; i++) begin
         pt = (i == 0) ? 128'h3243f6a8885a308d313198a2e0370734 : rand128();
         cycle(1'b1, 1'b1, encrypt(ak, pt), 8'(i), pt);
      end
      idle(11);
      chk("in_flight_peak", 128'(max_flight), 128'd10);

      // Gating: three refused blocks, then a normal one.
      dut_drops = 0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, rand128(), 8'(100 + i), '0);
      pt = rand128();
      cycle(1'b1, 1'b1, encrypt(ak, pt), 8'h77, pt);
      idle(11);
      chk("drop_count", 128'(dut_drops), 128'd3);

      // key_valid falls with blocks in flight; accepted blocks still complete.
      for (int i = 0; i < 2; i++) begin
         pt = rand128();
         cycle(1'b1, 1'b1, encrypt(ak, pt), 8'(200 + i), pt);
      end
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, rand128(), 8'h0f, '0);
      idle(11);

      // Alternating bubbles.
      for (int i = 0; i < 10; i++) begin
         pt = rand128();
         cycle(i % 2 == 0, 1'b1, encrypt(ak, pt), 8'(50 + i), pt);
      end
      idle(11);

      // Reset while five blocks are in flight.
      for (int i = 0; i < 5; i++) begin
         pt = rand128();
         cycle(1'b1, 1'b1, encrypt(ak, pt), 8'(i + 1), pt);
      end
      in_valid = 1'b0;
      idle(2);
      #2 reset = 1'b1;
      #1;
      clear_model();
      chk("rst_out_data", out_data, '0);
      chk("rst_busy", 128'(busy), '0);
      check_outputs();
      @(posedge clk);
      #1 reset = 1'b0;
      idle(20);

      // Random round trips, a fresh key for each block.
      for (int n = 0; n < 1000; n++) begin
         key = rand128();
         pt  = rand128();
         ak  = expand_key(key);
         ct  = encrypt(ak, pt);
         allKeys = ak;
         cycle(1'b1, 1'b1, ct, 8'($urandom_range(0, 255)), pt);
         idle(11);
      end

      chk("outs_vs_accepts", 128'(dut_outs), 128'(accepts));
      chk("pending_blocks", 128'(exp_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
